// File: rtl/map_irq_pkg.sv
// map_irq_pkg
// Shared constants and helpers for the mapper IRQ hub.
//   - Register indices inside the hub window (REG_MASK .. REG_VEC)
//   - ctrl register bit positions (timer enable, auto reload)
//   - Save-state base address (used only when IRQ_HUB_SST_EN is defined)
//   - TMR_W: timer width, fixed at 16
//   - prio_idx(): lowest-set-bit encoder for the vector readback
// Optional build macro: IRQ_HUB_SST_EN adds the save-state bus type.

package map_irq_pkg;

    localparam int TMR_W = 16;

    localparam logic [3:0] REG_MASK   = 4'd0;
    localparam logic [3:0] REG_PEND   = 4'd1;
    localparam logic [3:0] REG_RLD_LO = 4'd2;
    localparam logic [3:0] REG_RLD_HI = 4'd3;
    localparam logic [3:0] REG_CTRL   = 4'd4;
    localparam logic [3:0] REG_VEC    = 4'd5;

    localparam int CTRL_ON   = 0;
    localparam int CTRL_AUTO = 1;

    localparam logic [7:0] SST_BASE = 8'd24;

`ifdef IRQ_HUB_SST_EN
    typedef struct packed {
        logic       act_mc;
        logic       we_reg;
        logic [7:0] addr;
    } sst_bus_t;
`endif

    // Scanning from the top down lets the lowest set bit overwrite the rest.
    function automatic logic [2:0] prio_idx(input logic [7:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i])
                idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_hub_tmr.sv
// irq_hub_tmr
// CPU-cycle timer for the IRQ hub: detects rising edges of cpu_m2, counts a
// 16-bit down counter, reloads it and raises a one-clk fire pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cpu_m2            CPU M2 phase; rising edge is the timer tick
//   wr_rld_lo/hi      write reload low/high byte from wdata
//   ld_ctr            load counter with {wdata, reload low byte}
//   wr_ctrl           write ctrl bits (tmr_on, tmr_auto) from wdata
//   wdata             write data byte
//   reload            reload value readback
//   tmr_on, tmr_auto  ctrl readback
//   fire              one-clk pulse when the counter expires
//   (IRQ_HUB_SST_EN)  suspend, wr_ctr_lo/hi restore inputs, ctr readback

module irq_hub_tmr
    import map_irq_pkg::*;
#(
    parameter int TMR_W = map_irq_pkg::TMR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_m2,
    input  logic             wr_rld_lo,
    input  logic             wr_rld_hi,
    input  logic             ld_ctr,
    input  logic             wr_ctrl,
    input  logic [7:0]       wdata,
`ifdef IRQ_HUB_SST_EN
    input  logic             suspend,
    input  logic             wr_ctr_lo,
    input  logic             wr_ctr_hi,
    output logic [TMR_W-1:0] ctr,
`endif
    output logic [TMR_W-1:0] reload,
    output logic             tmr_on,
    output logic             tmr_auto,
    output logic             fire
);

`ifndef IRQ_HUB_SST_EN
    logic [TMR_W-1:0] ctr;
    logic             suspend;
    logic             wr_ctr_lo;
    logic             wr_ctr_hi;

    assign suspend   = 1'b0;
    assign wr_ctr_lo = 1'b0;
    assign wr_ctr_hi = 1'b0;
`endif

    logic m2_d;
    logic tick;
    logic run;

    // A counter load on the same clk as a tick swallows that tick entirely.
    assign tick = cpu_m2 & ~m2_d;
    assign run  = tick & tmr_on & ~suspend & ~ld_ctr;
    assign fire = run & (ctr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            m2_d     <= cpu_m2;
            ctr      <= '0;
            reload   <= '0;
            tmr_on   <= 1'b0;
            tmr_auto <= 1'b0;
        end else begin
            m2_d <= cpu_m2;

            if (wr_rld_lo)
                reload[7:0] <= wdata;
            if (wr_rld_hi)
                reload[15:8] <= wdata;

            if (ld_ctr) begin
                ctr <= {wdata, reload[7:0]};
            end else if (wr_ctr_lo || wr_ctr_hi) begin
                if (wr_ctr_lo)
                    ctr[7:0] <= wdata;
                if (wr_ctr_hi)
                    ctr[15:8] <= wdata;
            end else if (run) begin
                ctr <= fire ? reload : ctr - TMR_W'(1);
            end

            // One-shot mode disarms itself on expiry; the counter keeps the
            // reload value so a later re-enable starts a fresh period.
            if (wr_ctrl) begin
                tmr_on   <= wdata[CTRL_ON];
                tmr_auto <= wdata[CTRL_AUTO];
            end else if (fire && !tmr_auto) begin
                tmr_on <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/map_irq_hub.sv
// map_irq_hub
// Shares the mapper CPU IRQ line between SRC_NUM external requesters plus a
// built-in CPU-cycle timer (bit index SRC_NUM). Per-source mask, edge-set
// pending latch, write-1-to-clear acknowledge and a priority vector readback.
// Ports:
//   clk, map_rst   clock, synchronous active-high reset
//   cpu_m2         CPU M2 phase (timer tick on rising edge)
//   cpu_m3, cpu_rw register strobe qualifier and read/write (0 = write)
//   reg_addr       register index: 0 mask, 1 pending, 2/3 reload lo/hi,
//                  4 ctrl, 5 vector, others read 8'hFF
//   cpu_data       write data
//   irq_src        level requests; a rising edge latches a pending bit
//   reg_do         combinational readback
//   irq            registered IRQ to the pin driver
// Optional build macro: IRQ_HUB_SST_EN adds sst (save-state bus) and sst_di.

module map_irq_hub
    import map_irq_pkg::*;
#(
    parameter int SRC_NUM = 4,
    parameter int TMR_W   = map_irq_pkg::TMR_W
) (
    input  logic               clk,
    input  logic               map_rst,
    input  logic               cpu_m2,
    input  logic               cpu_m3,
    input  logic               cpu_rw,
    input  logic [3:0]         reg_addr,
    input  logic [7:0]         cpu_data,
    input  logic [SRC_NUM-1:0] irq_src,
`ifdef IRQ_HUB_SST_EN
    input  sst_bus_t           sst,
    output logic [7:0]         sst_di,
`endif
    output logic [7:0]         reg_do,
    output logic               irq
);

    logic               wr;
    logic               reg_wr;
    logic               hold;
    logic [7:0]         mask;
    logic [7:0]         pend;
    logic [7:0]         act;
    logic [7:0]         set_vec;
    logic [7:0]         ack_vec;
    logic [SRC_NUM-1:0] src_d;
    logic [SRC_NUM-1:0] rise;
    logic               mask_wr;
    logic               t_rld_lo;
    logic               t_rld_hi;
    logic               t_ld_ctr;
    logic               t_ctrl;
    logic               tmr_on;
    logic               tmr_auto;
    logic               tmr_fire;
    logic [TMR_W-1:0]   tmr_reload;

    assign wr   = cpu_m3 & ~cpu_rw;
    assign rise = irq_src & ~src_d;
    assign act  = pend & mask;

`ifdef IRQ_HUB_SST_EN
    localparam logic [7:0] PEND_VALID = 8'((9'd1 << (SRC_NUM + 1)) - 9'd1);

    logic             sst_wr;
    logic             pend_ld;
    logic             t_ctr_lo;
    logic             t_ctr_hi;
    logic [TMR_W-1:0] tmr_ctr;

    assign hold   = sst.act_mc;
    assign sst_wr = sst.act_mc & cpu_m3 & sst.we_reg;
`else
    assign hold = 1'b0;
`endif

    // While a save-state restore is active, normal register writes are
    // ignored and the restore port drives the same storage instead.
    always_comb begin
        reg_wr   = wr & ~hold;
        mask_wr  = reg_wr && (reg_addr == REG_MASK);
        ack_vec  = (reg_wr && (reg_addr == REG_PEND)) ? cpu_data : 8'h00;
        t_rld_lo = reg_wr && (reg_addr == REG_RLD_LO);
        t_rld_hi = reg_wr && (reg_addr == REG_RLD_HI);
        t_ld_ctr = reg_wr && (reg_addr == REG_RLD_HI);
        t_ctrl   = reg_wr && (reg_addr == REG_CTRL);
`ifdef IRQ_HUB_SST_EN
        pend_ld  = 1'b0;
        t_ctr_lo = 1'b0;
        t_ctr_hi = 1'b0;
        if (sst_wr) begin
            case (sst.addr)
                SST_BASE:         mask_wr  = 1'b1;
                SST_BASE + 8'd1:  pend_ld  = 1'b1;
                SST_BASE + 8'd2:  t_rld_lo = 1'b1;
                SST_BASE + 8'd3:  t_rld_hi = 1'b1;
                SST_BASE + 8'd4:  t_ctr_lo = 1'b1;
                SST_BASE + 8'd5:  t_ctr_hi = 1'b1;
                SST_BASE + 8'd6:  t_ctrl   = 1'b1;
                default:          ;
            endcase
        end
`endif
    end

    always_comb begin
        set_vec              = 8'h00;
        set_vec[SRC_NUM-1:0] = rise;
        set_vec[SRC_NUM]     = tmr_fire;
    end

    // Set has priority over acknowledge so a request arriving in the same
    // clk as its ack is never lost. irq follows pend/mask one clk later.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            src_d <= irq_src;
            mask  <= 8'h00;
            pend  <= 8'h00;
            irq   <= 1'b0;
        end else begin
            src_d <= irq_src;
            irq   <= |act;
            if (mask_wr)
                mask <= cpu_data;
`ifdef IRQ_HUB_SST_EN
            if (pend_ld)
                pend <= cpu_data & PEND_VALID;
            else if (!hold)
                pend <= (pend & ~ack_vec) | set_vec;
`else
            pend <= (pend & ~ack_vec) | set_vec;
`endif
        end
    end

    irq_hub_tmr #(
        .TMR_W (TMR_W)
    ) u_tmr (
        .clk       (clk),
        .rst       (map_rst),
        .cpu_m2    (cpu_m2),
        .wr_rld_lo (t_rld_lo),
        .wr_rld_hi (t_rld_hi),
        .ld_ctr    (t_ld_ctr),
        .wr_ctrl   (t_ctrl),
        .wdata     (cpu_data),
`ifdef IRQ_HUB_SST_EN
        .suspend   (hold),
        .wr_ctr_lo (t_ctr_lo),
        .wr_ctr_hi (t_ctr_hi),
        .ctr       (tmr_ctr),
`endif
        .reload    (tmr_reload),
        .tmr_on    (tmr_on),
        .tmr_auto  (tmr_auto),
        .fire      (tmr_fire)
    );

    always_comb begin
        case (reg_addr)
            REG_MASK:   reg_do = mask;
            REG_PEND:   reg_do = pend;
            REG_RLD_LO: reg_do = tmr_reload[7:0];
            REG_RLD_HI: reg_do = tmr_reload[15:8];
            REG_CTRL:   reg_do = {6'b0, tmr_auto, tmr_on};
            REG_VEC:    reg_do = {|act, 4'b0, prio_idx(act)};
            default:    reg_do = 8'hFF;
        endcase
    end

`ifdef IRQ_HUB_SST_EN
    always_comb begin
        case (sst.addr)
            SST_BASE:         sst_di = mask;
            SST_BASE + 8'd1:  sst_di = pend;
            SST_BASE + 8'd2:  sst_di = tmr_reload[7:0];
            SST_BASE + 8'd3:  sst_di = tmr_reload[15:8];
            SST_BASE + 8'd4:  sst_di = tmr_ctr[7:0];
            SST_BASE + 8'd5:  sst_di = tmr_ctr[15:8];
            SST_BASE + 8'd6:  sst_di = {6'b0, tmr_auto, tmr_on};
            default:          sst_di = 8'hFF;
        endcase
    end
`endif

endmodule

// File: tb/tb_map_irq_hub.sv
// tb_map_irq_hub
// Directed scoreboard bench for map_irq_hub: stimulus pushes expected values
// into a queue and a separate monitor pops and compares on each sample.

module tb_map_irq_hub;

    logic       clk = 1'b0;
    logic       map_rst;
    logic       cpu_m2;
    logic       cpu_m3;
    logic       cpu_rw;
    logic [3:0] reg_addr;
    logic [7:0] cpu_data;
    logic [3:0] irq_src;
    logic [7:0] reg_do;
    logic       irq;

    typedef struct {
        string      name;
        bit         is_irq;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event sample_ev;

    always #5 clk = ~clk;

    map_irq_hub #(
        .SRC_NUM (4),
        .TMR_W   (16)
    ) dut (
        .clk      (clk),
        .map_rst  (map_rst),
        .cpu_m2   (cpu_m2),
        .cpu_m3   (cpu_m3),
        .cpu_rw   (cpu_rw),
        .reg_addr (reg_addr),
        .cpu_data (cpu_data),
        .irq_src  (irq_src),
        .reg_do   (reg_do),
        .irq      (irq)
    );

    // Monitor: pops one expectation per sample strobe and compares.
    initial begin
        forever begin : mon
            exp_t       e;
            logic [7:0] got;
            @(sample_ev);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sample_without_expectation: got reg_do=%02h irq=%0b required none", reg_do, irq);
            end else begin
                e   = sb.pop_front();
                got = e.is_irq ? {7'b0, irq} : reg_do;
                if (got !== e.exp) begin
                    errors++;
                    $display("[TB] FAIL %s: got %02h required %02h", e.name, got, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
        reg_addr = addr;
        cpu_data = data;
        cpu_m3   = 1'b1;
        cpu_rw   = 1'b0;
        @(posedge clk);
        #1;
        cpu_m3   = 1'b0;
        cpu_rw   = 1'b1;
    endtask

    task automatic m2Tick();
        cpu_m2 = 1'b1;
        step(1);
        cpu_m2 = 1'b0;
        step(1);
    endtask

    task automatic checkOutput(input string name, input bit is_irq,
                               input logic [3:0] addr, input logic [7:0] exp);
        exp_t e;
        if (!is_irq)
            reg_addr = addr;
        e.name   = name;
        e.is_irq = is_irq;
        e.exp    = exp;
        sb.push_back(e);
        #1;
        -> sample_ev;
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_not_sampled: got queue depth %0d required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        map_rst  = 1'b1;
        cpu_m2   = 1'b0;
        cpu_m3   = 1'b0;
        cpu_rw   = 1'b1;
        reg_addr = 4'd0;
        cpu_data = 8'h00;
        irq_src  = 4'b0000;
        step(3);
        map_rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_mask", 0, 4'd0, 8'h00);
        checkOutput("rst_pend", 0, 4'd1, 8'h00);
        checkOutput("rst_ctrl", 0, 4'd4, 8'h00);
        step(1);
        checkOutput("rst_vec", 0, 4'd5, 8'h00);
        checkOutput("rst_unmapped", 0, 4'd6, 8'hFF);
        checkOutput("rst_irq", 1, 4'd0, 8'h00);
        step(1);

        $display("[TB] edge latch and ack latency");
        applyStimulus(4'd0, 8'h01);
        irq_src = 4'b0001;
        step(1);
        checkOutput("edge_irq_1clk", 1, 4'd0, 8'h00);
        checkOutput("edge_pend", 0, 4'd1, 8'h01);
        step(1);
        checkOutput("edge_irq_2clk", 1, 4'd0, 8'h01);
        checkOutput("edge_vec", 0, 4'd5, 8'h80);
        step(1);
        irq_src = 4'b0000;
        applyStimulus(4'd1, 8'h01);
        checkOutput("ack_irq_1clk", 1, 4'd0, 8'h01);
        step(1);
        checkOutput("ack_irq_2clk", 1, 4'd0, 8'h00);
        checkOutput("ack_pend", 0, 4'd1, 8'h00);
        step(1);

        $display("[TB] priority vector");
        applyStimulus(4'd0, 8'h0F);
        irq_src = 4'b0110;
        step(1);
        checkOutput("prio_vec_1", 0, 4'd5, 8'h81);
        step(1);
        applyStimulus(4'd1, 8'h02);
        checkOutput("prio_vec_2", 0, 4'd5, 8'h82);
        irq_src = 4'b0000;
        applyStimulus(4'd1, 8'h04);
        checkOutput("prio_vec_none", 0, 4'd5, 8'h00);
        step(1);

        $display("[TB] masked pending then unmask");
        applyStimulus(4'd0, 8'h00);
        irq_src = 4'b0100;
        step(2);
        checkOutput("masked_irq", 1, 4'd0, 8'h00);
        checkOutput("masked_pend", 0, 4'd1, 8'h04);
        step(1);
        applyStimulus(4'd0, 8'h04);
        checkOutput("unmask_irq_1clk", 1, 4'd0, 8'h00);
        step(1);
        checkOutput("unmask_irq_2clk", 1, 4'd0, 8'h01);
        step(1);
        applyStimulus(4'd1, 8'h04);
        irq_src = 4'b0000;
        step(2);
        checkOutput("unmask_ack_irq", 1, 4'd0, 8'h00);
        step(1);

        $display("[TB] set wins over ack");
        irq_src = 4'b1000;
        step(1);
        checkOutput("setwin_pre", 0, 4'd1, 8'h08);
        irq_src = 4'b0000;
        step(1);
        irq_src = 4'b1000;
        applyStimulus(4'd1, 8'h08);
        checkOutput("setwin_same_clk", 0, 4'd1, 8'h08);
        applyStimulus(4'd1, 8'h08);
        checkOutput("setwin_later_ack", 0, 4'd1, 8'h00);
        irq_src = 4'b0000;
        step(1);

        $display("[TB] one-shot timer");
        applyStimulus(4'd0, 8'h10);
        applyStimulus(4'd2, 8'h03);
        applyStimulus(4'd3, 8'h00);
        checkOutput("rld_lo", 0, 4'd2, 8'h03);
        checkOutput("rld_hi", 0, 4'd3, 8'h00);
        step(1);
        applyStimulus(4'd4, 8'h01);
        checkOutput("oneshot_ctrl_on", 0, 4'd4, 8'h01);
        repeat (3) m2Tick();
        checkOutput("oneshot_3_ticks", 0, 4'd1, 8'h00);
        m2Tick();
        checkOutput("oneshot_4th_tick", 0, 4'd1, 8'h10);
        checkOutput("oneshot_off", 0, 4'd4, 8'h00);
        checkOutput("oneshot_irq", 1, 4'd0, 8'h01);
        step(1);
        applyStimulus(4'd1, 8'h10);
        applyStimulus(4'd4, 8'h01);
        repeat (3) m2Tick();
        checkOutput("oneshot_rearm_3", 0, 4'd1, 8'h00);
        m2Tick();
        checkOutput("oneshot_rearm_4", 0, 4'd1, 8'h10);
        step(1);

        $display("[TB] auto timer reload 0 and coincident load");
        applyStimulus(4'd1, 8'h10);
        applyStimulus(4'd2, 8'h00);
        applyStimulus(4'd3, 8'h00);
        applyStimulus(4'd4, 8'h03);
        m2Tick();
        checkOutput("auto0_tick1", 0, 4'd1, 8'h10);
        applyStimulus(4'd1, 8'h10);
        m2Tick();
        checkOutput("auto0_tick2", 0, 4'd1, 8'h10);
        checkOutput("auto0_ctrl", 0, 4'd4, 8'h03);
        step(1);
        applyStimulus(4'd1, 8'h10);
        applyStimulus(4'd2, 8'h05);
        cpu_m2 = 1'b1;
        applyStimulus(4'd3, 8'h00);
        cpu_m2 = 1'b0;
        step(1);
        checkOutput("load_beats_tick", 0, 4'd1, 8'h00);
        repeat (5) m2Tick();
        checkOutput("auto5_5_ticks", 0, 4'd1, 8'h00);
        m2Tick();
        checkOutput("auto5_6th_tick", 0, 4'd1, 8'h10);
        checkOutput("auto5_ctrl", 0, 4'd4, 8'h03);
        step(1);

        $display("[TB] timer freeze and resume");
        applyStimulus(4'd1, 8'h10);
        applyStimulus(4'd4, 8'h02);
        repeat (3) m2Tick();
        checkOutput("frozen_no_fire", 0, 4'd1, 8'h00);
        applyStimulus(4'd4, 8'h03);
        repeat (5) m2Tick();
        checkOutput("resume_5_ticks", 0, 4'd1, 8'h00);
        m2Tick();
        checkOutput("resume_6th_tick", 0, 4'd1, 8'h10);
        applyStimulus(4'd4, 8'h00);
        applyStimulus(4'd1, 8'h10);
        step(1);

        $display("[TB] reset during pending irq");
        applyStimulus(4'd0, 8'h01);
        irq_src = 4'b0001;
        step(2);
        checkOutput("prerst_irq", 1, 4'd0, 8'h01);
        map_rst = 1'b1;
        step(1);
        checkOutput("rst_drops_irq", 1, 4'd0, 8'h00);
        checkOutput("rst_clears_pend", 0, 4'd1, 8'h00);
        map_rst = 1'b0;
        step(2);
        checkOutput("postrst_no_edge", 0, 4'd1, 8'h00);
        checkOutput("postrst_irq", 1, 4'd0, 8'h00);
        checkOutput("postrst_mask", 0, 4'd0, 8'h00);
        irq_src = 4'b0000;
        step(1);
        irq_src = 4'b0001;
        step(1);
        checkOutput("postrst_new_edge", 0, 4'd1, 8'h01);
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_irq_hub.md
Name: map_irq_hub

Overview:
Shares the single mapper CPU IRQ line between several interrupt requesters, for example a scanline counter or an expansion-audio frame IRQ.
Also contains one built-in 16-bit CPU-cycle timer that acts as the highest-numbered requester.
Provides per-source mask, pending latch, write-1-to-clear acknowledge, and a priority vector readback.
Sits between the mapper's IRQ sources and the cartridge IRQ pin, decoded from the mapper's register window.

Parameters:
SRC_NUM, 4, number of external IRQ sources (1..7); the timer uses bit index SRC_NUM.
TMR_W, 16, timer counter width (fixed at 16; exposed for package consistency only).

Ports:
clk  in  1  system clock; all logic is on posedge.
map_rst  in  1  synchronous, active-high reset.
cpu_m2  in  1  CPU M2 phase; its rising edge is the timer tick.
cpu_m3  in  1  register-access strobe qualifier.
cpu_rw  in  1  CPU read/write; 0 = write.
reg_addr  in  4  decoded register index inside the hub window.
cpu_data  in  8  CPU write data.
irq_src  in  SRC_NUM  level requests from sources; a rising edge means a new request.
reg_do  out  8  readback data, combinational from registers.
irq  out  1  registered, active-high IRQ to the CPU pin driver.
sst_* (IRQ_HUB_SST_EN only): sst (in SSTBus) and sst_di (out, 8 bits).

Behaviour:
- Write strobe: wr = cpu_m3 & !cpu_rw. A register write takes effect on the next clk edge.
- Register map:
  - 0: mask[7:0] (R/W).
  - 1: pending (read); writing 1s clears those bits.
  - 2: tmr_reload low byte (R/W).
  - 3: tmr_reload high byte (R/W); writing it also loads tmr_ctr <= {data, reload_lo}.
  - 4: ctrl (R/W): bit0 tmr_on, bit1 tmr_auto.
  - 5: vector (read only): {any, 4'b0, idx[2:0]}.
  - Other addresses read 8'hFF.
- Source edge detect: src_d <= irq_src every clk; rise[i] = irq_src[i] & !src_d[i]; pend[i] <= 1 on the next clk.
- Simultaneous rise and ack on the same bit: set wins, so the bit stays pending.
- Mask writes never alter pending bits. A masked pending bit asserts irq as soon as it is unmasked.
- irq <= |(pend & mask) each clk. Latency from a source rise to irq high is 2 clk. Latency from an ack write to irq low is 2 clk.
- Vector: idx is the lowest index i with pend[i] & mask[i]; any = irq-equivalent (combinational). When nothing qualifies, idx = 0 and any = 0.
- Timer:
  - Tick on m2 rising edge (m2_d registered); tick = cpu_m2 & !m2_d.
  - On tick with tmr_on: if tmr_ctr == 0, set pend[SRC_NUM] and reload tmr_ctr <= reload. If tmr_auto == 0, also clear tmr_on. Otherwise tmr_ctr <= tmr_ctr - 1.
  - Reload value 0 with auto enabled fires on every tick.
- Timer boundary cases:
  - A write to register 3 on the same clk as a tick: the load wins and the tick is discarded.
  - Clearing tmr_on freezes tmr_ctr; setting it again resumes from the frozen value.
- Reset (map_rst):
  - Cleared to 0: pend, mask, tmr_on, tmr_auto, tmr_ctr, reload, irq.
  - src_d <= irq_src and m2_d <= cpu_m2, so no spurious edge is detected on release.
  - Reset during a pending IRQ drops irq on the next clk.

Optional Feature:
IRQ_HUB_SST_EN:
- When defined, adds the sst ports.
- sst_di readback at sst.addr[7:0]: 24 = mask, 25 = pend, 26/27 = reload lo/hi, 28/29 = tmr_ctr lo/hi, 30 = ctrl, others 8'hFF.
- While sst.act_mc: on cpu_m3 & sst.we_reg, restore the same addresses, with mask restored before pend. Normal register, edge and tick logic is suspended, and irq is held at |(pend & mask).
- When undefined, there are no sst ports or logic, and behaviour is otherwise identical.

Decomposition:
- Package map_irq_pkg holds:
  - register index constants REG_MASK..REG_VEC;
  - ctrl bit positions;
  - sst address base 24;
  - localparam TMR_W;
  - function prio_idx (lowest-set-bit encoder).
- One sub-module, irq_hub_tmr, covers the m2 edge detect, the 16-bit counter and the reload/auto logic, with a single-clk fire output.

Test Plan:
- Edge latch: mask = 8'h01, pulse irq_src[0] high for 3 clk → pend = 8'h01 and irq = 1 two clk after the rise. Write 8'h01 to reg 1 → irq = 0 two clk later.
- Priority: mask = 8'h0F, rises on sources 2 and 1 → reg 5 reads 8'h81. Ack bit 1 → reads 8'h82.
- Set wins over ack: a rise on src 3 in the same clk as writing 8'h08 to reg 1 → pend[3] stays 1.
- One-shot timer: reload = 16'h0003, ctrl = 8'h01, 4 m2 ticks → pend[4] set on the 4th tick, then tmr_on = 0 and ctr = 3.
- Auto timer with reload 0: ctrl = 8'h03 → pend[4] set on every tick. A reg 3 write coincident with a tick loads and does not decrement.
- Reset: map_rst while irq = 1 and irq_src held high → irq = 0 next clk, and after release no pending bit sets until a new rising edge.
